// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package imem_ctrl_pkg;

    localparam int DEFAULT_DEPTH  = 64;
    localparam int DEFAULT_AW     = 6;
    localparam int BYTES_PER_WORD = 4;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        RUN    = 2'd3
    } state_t;

endpackage

// File: rtl/imem_boot_ctrl_word_packer.sv
// Assembles four accepted stream bytes into one little-endian 32-bit word.
module word_packer
    import imem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    output logic        word_ready,
    output logic [31:0] word
);

    logic [BCNT_W-1:0] byte_cnt;
    logic [31:0]       asm_q;

    // The last byte is merged combinationally so the FSM can register the
    // complete word on the same edge that accepts byte 3.
    always_comb begin
        word = asm_q;
        word[{byte_cnt, 3'b000} +: 8] = byte_data;
    end

    assign word_ready = accept && (byte_cnt == BCNT_W'(BYTES_PER_WORD - 1));

    // Byte lane counter and assembly register; counter wraps after byte 3.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byte_cnt <= '0;
            asm_q    <= '0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 1'b1;
            asm_q    <= word;
        end
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Owns the instruction-memory port: loads a program from a byte stream while
// holding the core in reset, then hands the port to CPU fetch.
module imem_boot_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   load_len,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    input  logic          cpu_fetch_req,
    input  logic [31:0]   cpu_fetch_addr,
    output logic          mem_we,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_reset,
    output logic          cpu_stall,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t         state, state_nxt;
    logic [AW:0]    len_q;
    logic [AW:0]    word_cnt;
    logic [AW-1:0]  wr_addr_q;

    logic           accept;
    logic           start_ok;
    logic           start_bad;
    logic           pk_clear;
    logic           pk_word_ready;
    logic [31:0]    pk_word;

    // Only the word-index bits of the PC select a memory entry.
    logic           unused_fetch_bits;
    assign unused_fetch_bits = ^{cpu_fetch_addr[31:AW+2], cpu_fetch_addr[1:0]};

    assign accept    = byte_valid && byte_ready;
    // Start is honoured only when no load is in flight.
    assign start_ok  = start && (state == IDLE || state == RUN) && (load_len <= DEPTH_L);
    assign start_bad = start && (state == IDLE || state == RUN) && (load_len >  DEPTH_L);
    assign pk_clear  = start_ok;

    word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pk_clear),
        .accept     (accept),
        .byte_data  (byte_data),
        .word_ready (pk_word_ready),
        .word       (pk_word)
    );

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RUN: begin
                if (start_ok)
                    state_nxt = (load_len == '0) ? RUN : LOAD;
                else if (start_bad)
                    state_nxt = IDLE;
            end
            LOAD: begin
                if (pk_word_ready)
                    state_nxt = COMMIT;
            end
            COMMIT: begin
                state_nxt = (word_cnt + 1'b1 == len_q) ? RUN : LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, counters and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            len_q      <= '0;
            word_cnt   <= '0;
            wr_addr_q  <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            byte_ready <= 1'b0;
            cpu_reset  <= 1'b1;
            cpu_stall  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            mem_we     <= 1'b0;
            byte_ready <= (state_nxt == LOAD);
            busy       <= (state_nxt == LOAD) || (state_nxt == COMMIT);
            done       <= (state_nxt == RUN);
            cpu_reset  <= (state_nxt != RUN);
            cpu_stall  <= (state_nxt != RUN);

            if (start_ok) begin
                err      <= 1'b0;
                len_q    <= load_len;
                word_cnt <= '0;
            end else if (start_bad) begin
                err <= 1'b1;
            end

            if (state == LOAD && pk_word_ready) begin
                mem_we    <= 1'b1;
                mem_wdata <= pk_word;
                wr_addr_q <= word_cnt[AW-1:0];
            end

            if (state == COMMIT)
                word_cnt <= word_cnt + 1'b1;
        end
    end

    // Fetch path is combinational in RUN; the write address is used otherwise.
    always_comb begin
        mem_rd_en = (state == RUN) && cpu_fetch_req;
        mem_addr  = (state == RUN) ? cpu_fetch_addr[AW+1:2] : wr_addr_q;
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl with a write scoreboard and memory model.
module tb_imem_boot_ctrl;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   load_len = '0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready;
    logic          cpu_fetch_req = 1'b0;
    logic [31:0]   cpu_fetch_addr = '0;
    logic          mem_we;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_reset;
    logic          cpu_stall;
    logic          busy;
    logic          done;
    logic          err;

    imem_boot_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .load_len       (load_len),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .byte_ready     (byte_ready),
        .cpu_fetch_req  (cpu_fetch_req),
        .cpu_fetch_addr (cpu_fetch_addr),
        .mem_we         (mem_we),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .cpu_reset      (cpu_reset),
        .cpu_stall      (cpu_stall),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;
    wr_t exp_q[$];

    // Simple synchronous memory with one-cycle read latency.
    logic [31:0] mem_model [DEPTH];
    logic [31:0] rdata;
    always @(posedge clk) begin
        if (mem_we) mem_model[mem_addr] <= mem_wdata;
        if (mem_rd_en) rdata <= mem_model[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every memory write must match the next expected write.
    always @(negedge clk) begin
        wr_t e;
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                chk("wr_data", mem_wdata, e.data);
                chk("commit_byte_ready", 32'(byte_ready), 32'd0);
                chk("commit_cpu_reset", 32'(cpu_reset), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [AW:0] len);
        start = 1'b1;
        load_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data = b;
        @(negedge clk);
        while (!byte_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: got byte_ready=0 expected 1 within 50 cycles");
            byte_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if (gap) begin
                byte_valid = 1'b0;
                tick();
            end
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        chk("done_reached", 32'(done), 32'd1);
    endtask

    task automatic fetch_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        cpu_fetch_req = 1'b1;
        cpu_fetch_addr = addr;
        tick();
        chk(name, rdata, exp);
        cpu_fetch_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        tick();

        // Load two words with a continuous byte stream
        push_wr(6'd0, 32'h0050_0013);
        push_wr(6'd1, 32'h0010_0093);
        pulse_start(7'd2);
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_byte_ready", 32'(byte_ready), 32'd1);
        chk("load_cpu_reset", 32'(cpu_reset), 32'd1);
        send_word(32'h0050_0013, 1'b0);
        send_word(32'h0010_0093, 1'b0);
        byte_valid = 1'b0;
        wait_done();
        chk("run_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("run_cpu_stall", 32'(cpu_stall), 32'd0);
        chk("run_busy", 32'(busy), 32'd0);
        chk("load1_queue_empty", 32'(exp_q.size()), 32'd0);

        // Fetch address mapping and wrap
        cpu_fetch_req = 1'b1;
        cpu_fetch_addr = 32'h0000_0104;
        #1;
        chk("fetch_addr", 32'(mem_addr), 32'd1);
        chk("fetch_rd_en", 32'(mem_rd_en), 32'd1);
        cpu_fetch_addr = 32'h0000_0204;
        #1;
        chk("fetch_wrap", 32'(mem_addr), 32'd1);
        cpu_fetch_req = 1'b0;
        #1;
        chk("fetch_no_req", 32'(mem_rd_en), 32'd0);
        fetch_check("read_w0", 32'h0000_0000, 32'h0050_0013);
        fetch_check("read_w1", 32'h0000_0004, 32'h0010_0093);

        // Length bounds
        pulse_start(7'd0);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        pulse_start(7'd65);
        chk("len65_err", 32'(err), 32'd1);
        chk("len65_done", 32'(done), 32'd0);
        chk("len65_busy", 32'(busy), 32'd0);
        chk("len65_cpu_reset", 32'(cpu_reset), 32'd1);
        tick();
        chk("err_sticky", 32'(err), 32'd1);
        chk("idle_rd_en", 32'(mem_rd_en), 32'd0);
        push_wr(6'd0, 32'h4433_2211);
        pulse_start(7'd1);
        chk("len1_err_clr", 32'(err), 32'd0);
        chk("len1_busy", 32'(busy), 32'd1);
        send_word(32'h4433_2211, 1'b1);
        wait_done();

        // Byte-stream gaps across two words, started from RUN
        push_wr(6'd0, 32'hDEAD_BEEF);
        push_wr(6'd1, 32'h0102_0304);
        pulse_start(7'd2);
        send_word(32'hDEAD_BEEF, 1'b1);
        send_word(32'h0102_0304, 1'b1);
        wait_done();
        fetch_check("gap_read_w0", 32'h0000_0000, 32'hDEAD_BEEF);

        // Reset in the middle of word 1
        push_wr(6'd0, 32'hCAFE_F00D);
        pulse_start(7'd2);
        send_word(32'hCAFE_F00D, 1'b0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        byte_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("mid_rst_cpu_stall", 32'(cpu_stall), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
        tick();
        tick();
        pulse_start(7'd0);
        chk("mid_rst_run", 32'(done), 32'd1);
        fetch_check("mid_rst_w0", 32'h0000_0000, 32'hCAFE_F00D);
        fetch_check("mid_rst_w1_kept", 32'h0000_0004, 32'h0102_0304);

        // Reload from RUN
        push_wr(6'd0, 32'h1234_5678);
        pulse_start(7'd1);
        chk("reload_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("reload_cpu_stall", 32'(cpu_stall), 32'd1);
        chk("reload_done", 32'(done), 32'd0);
        chk("reload_busy", 32'(busy), 32'd1);
        send_word(32'h1234_5678, 1'b0);
        byte_valid = 1'b0;
        wait_done();
        chk("reload_run_cpu_reset", 32'(cpu_reset), 32'd0);
        fetch_check("reload_w0", 32'h0000_0000, 32'h1234_5678);
        tick();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
Controller that owns the instruction-memory port. After reset it keeps the core held in reset. It then loads a program from a byte stream into instruction memory as little-endian 32-bit words, written at sequential word addresses. Once loading completes it releases the core and hands the memory port to CPU fetch, translating the PC byte address to a word index. It sits between the boot/debug byte source, the core's fetch stage and the instruction memory.

Parameters:
DEPTH, 64, instruction memory depth in words
AW, 6, word address width, equal to log2(DEPTH)

Ports:
clk  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins a load
load_len  in  AW+1  number of words to load; sampled when start is high
byte_valid  in  1  byte stream valid
byte_data  in  8  byte stream data
byte_ready  out  1  byte accepted when byte_valid and byte_ready are both high
cpu_fetch_req  in  1  core fetch request
cpu_fetch_addr  in  32  PC byte address
mem_we  out  1  instruction memory write enable
mem_rd_en  out  1  instruction memory read enable
mem_addr  out  AW  instruction memory word address
mem_wdata  out  32  instruction memory write data
cpu_reset  out  1  holds the core in reset
cpu_stall  out  1  stalls fetch
busy  out  1  high in LOAD and COMMIT
done  out  1  high in RUN
err  out  1  sticky length error

Behaviour:
- Single clock domain, clk. reset is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values: state=IDLE; cpu_reset=1; cpu_stall=1; every other output 0; byte and word counters 0; assembly register 0.
- Memory contents are never cleared by this block.
- IDLE: byte_ready=0.
  - start with load_len in 1..DEPTH: go to LOAD, clear counters and err.
  - start with load_len==0: go straight to RUN.
  - start with load_len>DEPTH: err=1, stay in IDLE.
- LOAD: byte_ready=1. Each accepted byte k (k=0..3) goes into assembly bits [8k+7:8k]. Accepting byte 3 moves to COMMIT on the next edge.
- COMMIT (exactly 1 cycle): byte_ready=0; mem_we=1; mem_addr=word_cnt; mem_wdata=assembled word. word_cnt then increments.
  - If word_cnt+1==len: go to RUN.
  - Otherwise: return to LOAD.
- Peak throughput is 5 cycles per word.
- RUN: cpu_reset=0, cpu_stall=0, done=1, byte_ready=0.
  - mem_rd_en = cpu_fetch_req (combinational).
  - mem_addr = cpu_fetch_addr[AW+1:2] (combinational); upper address bits are ignored, so addresses wrap modulo DEPTH.
  - Read data arrives from the memory one cycle later; that latency is the memory's, not added here.
- mem_we, mem_wdata and state-derived outputs are registered. mem_wdata holds its last value outside COMMIT.
- cpu_reset and cpu_stall are 1 in IDLE, LOAD and COMMIT.
- start in RUN: reload. The next state is LOAD (or IDLE with err=1 if load_len>DEPTH). cpu_reset reasserts in that same cycle. mem_rd_en is forced 0 outside RUN.
- start in LOAD or COMMIT is ignored.
- byte_valid while byte_ready=0 is not accepted, and the byte source must hold the byte.
- Reset mid-load: return to IDLE immediately; the partial word is discarded; words already written stay in memory.
- err clears only on a valid start or on reset.

Decomposition:
- Package imem_ctrl_pkg holds:
  - the state enum (IDLE, LOAD, COMMIT, RUN);
  - DEPTH/AW defaults;
  - the byte-lane constant BYTES_PER_WORD=4.
- One sub-module, word_packer: a 2-bit byte counter plus a 32-bit shift/assembly register. Outputs word_ready and word; clear input driven from the FSM.

Test Plan:
- Load after reset: reset 2 cycles; start with load_len=2; bytes 13,00,50,00,93,00,10,00 -> mem_we pulses at addr 0 with 0x00500013 and at addr 1 with 0x00100093; then done=1, cpu_reset=0.
- Fetch mapping in RUN: cpu_fetch_req=1 with cpu_fetch_addr=0x0000_0104 -> mem_addr=1 and mem_rd_en=1 in the same cycle.
- Length bounds: load_len=0 -> RUN with no writes; load_len=65 -> err=1, state stays IDLE, and err clears on the next start with load_len=1.
- Byte-stream gaps: byte_valid toggling 1/0 each cycle -> the word is assembled correctly; byte_ready=0 in the COMMIT cycle and no byte is lost or duplicated.
- Reset mid-load: reset after 2 bytes of word 1 -> word 0 remains in memory; IDLE outputs are restored on the next edge; no mem_we is issued for word 1.
- Reload: start with load_len=1 while in RUN -> cpu_reset=1 and cpu_stall=1 on the next cycle; addr 0 is rewritten; RUN is re-entered.
